qdot_acc: RTL and testbench
===========================

QDOT_ACC -- requirements
Module: qdot_acc

Interface
REQ-001 Parameter N, default 32, total word width of signed fixed-point operands and result.
REQ-002 Parameter Q, default 18, fraction length; carried for format consistency, no realignment performed.
REQ-003 Parameter MAX_LEN, default 16, maximum elements per vector; CW = clog2(MAX_LEN+1).
REQ-004 clk  in  1  single clock, all logic rising-edge.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 in_valid  in  1  product beat present.
REQ-007 in_ready  out  1  block accepts beat.
REQ-008 in_data  in  N  signed Q-format product from the multiplier stage.
REQ-009 in_ovr  in  1  multiplier overflow flag for this beat.
REQ-010 in_last  in  1  final element of the current vector.
REQ-011 out_valid  out  1  result available.
REQ-012 out_ready  in  1  consumer accepts result.
REQ-013 out_data  out  N  saturated signed dot-product sum, Q-format.
REQ-014 out_ovr  out  1  sticky: any in_ovr or accumulator saturation within vector.
REQ-015 out_trunc  out  1  vector ended by MAX_LEN, not in_last.
REQ-016 out_count  out  CW  number of beats accumulated.

Function
REQ-017 States SHALL be IDLE, ACC, HOLD; in_ready SHALL equal (state != HOLD).
REQ-018 Beat accepted iff in_valid && in_ready; no other input changes state.
REQ-019 IDLE, beat accepted: acc = in_data (saturation impossible), count = 1, ovr = in_ovr; next state ACC, or HOLD if terminating.
REQ-020 ACC, beat accepted: acc = sat(acc + in_data) computed at N+1 bits, count += 1, ovr |= in_ovr | saturated.
REQ-021 sat: sum > 2^(N-1)-1 -> 2^(N-1)-1; sum < -2^(N-1) -> -2^(N-1); else sum[N-1:0].
REQ-022 Beat terminates vector if in_last, or if it is beat number MAX_LEN (then out_trunc = 1 unless in_last also set).
REQ-023 Terminating beat -> HOLD; out_valid SHALL rise on the cycle after the terminating beat's edge (latency 1).
REQ-024 HOLD: out_valid = 1; out_data, out_ovr, out_trunc, out_count stable until out_valid && out_ready.
REQ-025 Output handshake -> IDLE next cycle; acc, count, flags cleared; out_valid = 0.
REQ-026 in_valid asserted during HOLD SHALL be ignored and not consumed.
REQ-027 Outputs SHALL be registered; no combinational path in_* -> out_*.

Reset
REQ-028 rst_n low at edge: state IDLE, acc 0, out_data 0, out_valid 0, out_ovr 0, out_trunc 0, out_count 0, in_ready 1 after release.
REQ-029 Reset mid-vector or during HOLD SHALL discard partial/pending result; next vector starts from zero.

Structure
REQ-030 State encoding and saturation limit constants SHALL live in shared package qfix_pkg.
REQ-031 One sub-module qsat_add (combinational N+1-bit add with saturate and sat flag) SHALL be used; remainder flat.

Verification (N=32, Q=18, 1.0 = 0x0004_0000)
REQ-032 Beats 0x0004_0000, 0x0008_0000, 0xFFFE_0000 (last) -> out_data 0x000A_0000, out_count 3, out_ovr 0, out_valid one cycle after last.
REQ-033 Beats 0x7FFF_0000, 0x0010_0000 (last) -> out_data 0x7FFF_FFFF, out_ovr 1; mirror 0x8001_0000 + 0xFFF0_0000 -> 0x8000_0000.
REQ-034 Two beats 0x0004_0000, second with in_ovr=1 -> out_data 0x0008_0000, out_ovr 1.
REQ-035 out_ready low 5 cycles with in_valid held high -> out_valid and out_data stable, in_ready 0, no beat consumed; release -> IDLE next cycle.
REQ-036 MAX_LEN=4, four beats 0x0004_0000, no in_last -> out_data 0x0010_0000, out_count 4, out_trunc 1.
REQ-037 rst_n low after 2 beats, then one beat 0x0004_0000 (last) -> out_data 0x0004_0000, out_count 1.

Source files
------------

// File: rtl/qfix_pkg.sv
// rtl/qfix_pkg.sv - shared fixed-point state encoding and saturation limits
//
// Contents:
//   qstate_e      accumulator control states (IDLE, ACC, HOLD)
//   QFIX_MAX_W    widest word the limit helpers can describe
//   sat_max_val   largest signed value of an n-bit word, zero-extended to 64 bits
//   sat_min_val   most negative signed value of an n-bit word, low n bits valid
package qfix_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } qstate_e;

    localparam int QFIX_MAX_W = 64;

    // The callers cast the result down to their own width.
    function automatic logic [QFIX_MAX_W-1:0] sat_max_val(input int n);
        return (64'd1 << (n - 1)) - 64'd1;
    endfunction

    function automatic logic [QFIX_MAX_W-1:0] sat_min_val(input int n);
        return 64'd1 << (n - 1);
    endfunction

endpackage

// File: rtl/qsat_add.sv
// rtl/qsat_add.sv - combinational signed add with saturation to N bits
//
// Ports:
//   a, b   in  N  signed operands
//   sum    out N  saturated signed sum
//   sat    out 1  sum was clipped to a limit
module qsat_add
    import qfix_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] sum,
    output logic         sat
);

    localparam logic [N-1:0] SAT_MAX = N'(sat_max_val(N));
    localparam logic [N-1:0] SAT_MIN = N'(sat_min_val(N));

    logic [N:0] wide;

    // One guard bit is enough for the sum of two N-bit values; a mismatch
    // between the guard bit and the N-bit sign means the result overflowed,
    // and the guard bit tells which direction.
    assign wide = {a[N-1], a} + {b[N-1], b};

    always_comb begin
        sum = wide[N-1:0];
        sat = 1'b0;
        if (wide[N] != wide[N-1]) begin
            sat = 1'b1;
            sum = wide[N] ? SAT_MIN : SAT_MAX;
        end
    end

endmodule

// File: rtl/qdot_acc.sv
// rtl/qdot_acc.sv - saturating dot-product accumulator for Q-format products
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   in_valid/in_ready/in_data       product beat stream from the multiplier
//   in_ovr, in_last                 per-beat overflow flag, end-of-vector marker
//   out_valid/out_ready/out_data    saturated vector sum, held until accepted
//   out_ovr                         any input overflow or saturation in the vector
//   out_trunc                       vector closed by MAX_LEN rather than in_last
//   out_count                       beats accumulated in the vector
module qdot_acc
    import qfix_pkg::*;
#(
    parameter int N       = 32,
    parameter int Q       = 18,
    parameter int MAX_LEN = 16,
    localparam int CW     = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic          in_ovr,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data,
    output logic          out_ovr,
    output logic          out_trunc,
    output logic [CW-1:0] out_count
);

    // Q is only carried so the format travels with the instance; the sum is
    // never realigned, but a fraction wider than the word is still nonsense.
    if (Q >= N) begin : g_bad_q
        $error("qdot_acc: Q must be smaller than N");
    end

    qstate_e       state;
    logic [N-1:0]  acc;
    logic [CW-1:0] count;
    logic          ovr;
    logic          trunc;

    logic          accept;
    logic [N-1:0]  add_a;
    logic [N-1:0]  add_sum;
    logic          add_sat;
    logic [CW-1:0] count_next;
    logic          hit_max;
    logic          term;

    assign in_ready  = (state != ST_HOLD);
    assign out_valid = (state == ST_HOLD);
    assign out_data  = acc;
    assign out_ovr   = ovr;
    assign out_trunc = trunc;
    assign out_count = count;

    assign accept = in_valid && in_ready;

    // The first beat of a vector loads rather than adds; feeding zero into
    // the adder makes that a plain pass-through that can never saturate.
    assign add_a = (state == ST_ACC) ? acc : '0;

    qsat_add #(
        .N (N)
    ) u_sat_add (
        .a   (add_a),
        .b   (in_data),
        .sum (add_sum),
        .sat (add_sat)
    );

    assign count_next = (state == ST_ACC) ? count + CW'(1) : CW'(1);
    assign hit_max    = (count_next == CW'(MAX_LEN));
    assign term       = in_last || hit_max;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            acc   <= '0;
            count <= '0;
            ovr   <= 1'b0;
            trunc <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_ACC: begin
                    if (accept) begin
                        acc   <= add_sum;
                        count <= count_next;
                        ovr   <= ((state == ST_ACC) && ovr) | in_ovr | add_sat;
                        trunc <= hit_max && !in_last;
                        state <= term ? ST_HOLD : ST_ACC;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                        acc   <= '0;
                        count <= '0;
                        ovr   <= 1'b0;
                        trunc <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    acc   <= '0;
                    count <= '0;
                    ovr   <= 1'b0;
                    trunc <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qdot_acc.sv
// tb/tb_qdot_acc.sv - self-checking bench for qdot_acc
module tb_qdot_acc;

    localparam int N       = 32;
    localparam int Q       = 18;
    localparam int MAX_LEN = 4;
    localparam int CW      = $clog2(MAX_LEN + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic          in_ovr;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_data;
    logic          out_ovr;
    logic          out_trunc;
    logic [CW-1:0] out_count;

    always #5 clk = ~clk;

    qdot_acc #(
        .N       (N),
        .Q       (Q),
        .MAX_LEN (MAX_LEN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ovr    (in_ovr),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovr   (out_ovr),
        .out_trunc (out_trunc),
        .out_count (out_count)
    );

    typedef struct packed {
        logic [N-1:0]  data;
        logic          ovr;
        logic          trunc;
        logic [CW-1:0] count;
    } exp_t;

    exp_t         sb[$];
    int           total = 0;
    int           bad   = 0;
    logic [N-1:0] bd[8];
    logic         bo[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_ovr    = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Model the vector in bd/bo, push the expected result, then drive it.
    task automatic run_vector(input int len, input bit with_last);
        longint mx;
        longint mn;
        longint acc;
        longint s;
        longint d;
        exp_t   e;
        mx    = 64'sd2147483647;
        mn    = -64'sd2147483648;
        acc   = 0;
        e.ovr = 1'b0;
        for (int i = 0; i < len; i++) begin
            d = longint'($signed(bd[i]));
            if (i == 0) begin
                acc = d;
            end else begin
                s = acc + d;
                if (s > mx) begin
                    acc   = mx;
                    e.ovr = 1'b1;
                end else if (s < mn) begin
                    acc   = mn;
                    e.ovr = 1'b1;
                end else begin
                    acc = s;
                end
            end
            e.ovr = e.ovr | bo[i];
        end
        e.data  = acc[N-1:0];
        e.count = CW'(len);
        e.trunc = (len == MAX_LEN) && !with_last;
        sb.push_back(e);

        for (int i = 0; i < len; i++) begin
            in_valid = 1'b1;
            in_data  = bd[i];
            in_ovr   = bo[i];
            in_last  = with_last && (i == len - 1);
            total++;
            if (in_ready !== 1'b1) begin
                bad++;
                $display("FAIL beat_ready: beat %0d in_ready=%b want 1", i, in_ready);
            end
            tick();
            total++;
            if (out_valid !== (i == len - 1)) begin
                bad++;
                $display("FAIL latency: after beat %0d out_valid=%b want %b", i, out_valid, (i == len - 1));
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_ovr   = 1'b0;
    endtask

    task automatic check_result(input string name);
        int   waited;
        exp_t e;
        waited = 0;
        while (out_valid !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s_timeout: out_valid=%b want 1", name, out_valid);
            return;
        end
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL %s_scoreboard: result present, queue size 0 want >0", name);
            return;
        end
        e = sb.pop_front();
        total++;
        if (out_data !== e.data) begin
            bad++;
            $display("FAIL %s_data: got %h want %h", name, out_data, e.data);
        end
        total++;
        if (out_ovr !== e.ovr) begin
            bad++;
            $display("FAIL %s_ovr: got %b want %b", name, out_ovr, e.ovr);
        end
        total++;
        if (out_trunc !== e.trunc) begin
            bad++;
            $display("FAIL %s_trunc: got %b want %b", name, out_trunc, e.trunc);
        end
        total++;
        if (out_count !== e.count) begin
            bad++;
            $display("FAIL %s_count: got %0d want %0d", name, out_count, e.count);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_count !== '0 || out_data !== '0) begin
            bad++;
            $display("FAIL %s_release: valid=%b ready=%b count=%0d data=%h want 0 1 0 0",
                     name, out_valid, in_ready, out_count, out_data);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", in_ready); end
        total++;
        if (out_data !== '0) begin bad++; $display("FAIL rst_data: got %h want 0", out_data); end
        total++;
        if (out_count !== '0) begin bad++; $display("FAIL rst_count: got %0d want 0", out_count); end
        total++;
        if (out_ovr !== 1'b0 || out_trunc !== 1'b0) begin
            bad++;
            $display("FAIL rst_flags: ovr=%b trunc=%b want 0 0", out_ovr, out_trunc);
        end
    endtask

    task automatic test_basic();
        bd[0] = 32'h0004_0000; bo[0] = 1'b0;
        bd[1] = 32'h0008_0000; bo[1] = 1'b0;
        bd[2] = 32'hFFFE_0000; bo[2] = 1'b0;
        run_vector(3, 1'b1);
        total++;
        if (out_data !== 32'h000A_0000 || out_count !== 3'd3 || out_ovr !== 1'b0) begin
            bad++;
            $display("FAIL basic_const: data=%h count=%0d ovr=%b want 000a0000 3 0", out_data, out_count, out_ovr);
        end
        check_result("basic");
    endtask

    task automatic test_saturate();
        bd[0] = 32'h7FFF_0000; bo[0] = 1'b0;
        bd[1] = 32'h0010_0000; bo[1] = 1'b0;
        run_vector(2, 1'b1);
        total++;
        if (out_data !== 32'h7FFF_FFFF || out_ovr !== 1'b1) begin
            bad++;
            $display("FAIL sat_pos_const: data=%h ovr=%b want 7fffffff 1", out_data, out_ovr);
        end
        check_result("sat_pos");
        bd[0] = 32'h8001_0000; bo[0] = 1'b0;
        bd[1] = 32'hFFF0_0000; bo[1] = 1'b0;
        run_vector(2, 1'b1);
        total++;
        if (out_data !== 32'h8000_0000 || out_ovr !== 1'b1) begin
            bad++;
            $display("FAIL sat_neg_const: data=%h ovr=%b want 80000000 1", out_data, out_ovr);
        end
        check_result("sat_neg");
    endtask

    task automatic test_in_ovr();
        bd[0] = 32'h0004_0000; bo[0] = 1'b0;
        bd[1] = 32'h0004_0000; bo[1] = 1'b1;
        run_vector(2, 1'b1);
        total++;
        if (out_data !== 32'h0008_0000 || out_ovr !== 1'b1) begin
            bad++;
            $display("FAIL in_ovr_const: data=%h ovr=%b want 00080000 1", out_data, out_ovr);
        end
        check_result("in_ovr");
    endtask

    task automatic test_hold();
        bd[0] = 32'h0004_0000; bo[0] = 1'b0;
        run_vector(1, 1'b1);
        in_valid = 1'b1;
        in_data  = 32'h1234_0000;
        in_last  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            total++;
            if (out_valid !== 1'b1 || out_data !== 32'h0004_0000 || in_ready !== 1'b0 || out_count !== 3'd1) begin
                bad++;
                $display("FAIL hold_stable: cycle %0d valid=%b data=%h ready=%b count=%0d want 1 00040000 0 1",
                         c, out_valid, out_data, in_ready, out_count);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_result("hold");
        tick();
        total++;
        if (out_valid !== 1'b0 || out_count !== '0) begin
            bad++;
            $display("FAIL hold_no_consume: valid=%b count=%0d want 0 0", out_valid, out_count);
        end
    endtask

    task automatic test_trunc();
        for (int i = 0; i < 4; i++) begin
            bd[i] = 32'h0004_0000;
            bo[i] = 1'b0;
        end
        run_vector(4, 1'b0);
        total++;
        if (out_data !== 32'h0010_0000 || out_count !== 3'd4 || out_trunc !== 1'b1) begin
            bad++;
            $display("FAIL trunc_const: data=%h count=%0d trunc=%b want 00100000 4 1", out_data, out_count, out_trunc);
        end
        check_result("trunc");
        run_vector(4, 1'b1);
        total++;
        if (out_trunc !== 1'b0) begin
            bad++;
            $display("FAIL trunc_with_last: got %b want 0", out_trunc);
        end
        check_result("full_last");
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h0004_0000;
            in_ovr   = 1'b1;
            in_last  = 1'b0;
            tick();
        end
        apply_reset();
        total++;
        if (out_count !== '0 || out_data !== '0 || out_valid !== 1'b0 || out_ovr !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_clear: count=%0d data=%h valid=%b ovr=%b want 0 0 0 0",
                     out_count, out_data, out_valid, out_ovr);
        end
        bd[0] = 32'h0004_0000; bo[0] = 1'b0;
        run_vector(1, 1'b1);
        total++;
        if (out_data !== 32'h0004_0000 || out_count !== 3'd1) begin
            bad++;
            $display("FAIL rst_mid_const: data=%h count=%0d want 00040000 1", out_data, out_count);
        end
        check_result("rst_mid");
        bd[0] = 32'h0008_0000; bo[0] = 1'b1;
        run_vector(1, 1'b1);
        void'(sb.pop_back());
        apply_reset();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin
            bad++;
            $display("FAIL rst_hold_clear: valid=%b ready=%b data=%h want 0 1 0", out_valid, in_ready, out_data);
        end
    endtask

    task automatic test_back_to_back();
        int len;
        bit with_last;
        for (int v = 0; v < 24; v++) begin
            len       = $urandom_range(1, MAX_LEN);
            with_last = (len < MAX_LEN) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 1) == 0) begin
                    bd[i] = $urandom;
                end else begin
                    bd[i] = N'($signed(20'($urandom)));
                end
                bo[i] = ($urandom_range(0, 7) == 0);
            end
            run_vector(len, with_last);
            check_result("b2b");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_in_ovr();
        test_hold();
        test_trunc();
        test_reset_mid();
        test_back_to_back();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d left want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached want finish");
        $fatal(1, "watchdog");
    end

endmodule
